dlx_mem_arbiter: RTL and testbench
==================================

Name: dlx_mem_arbiter

Overview:
- Shares one single-ported external memory bus between the uDLX core's instruction-fetch port and its data port.
- Sits between dlx_processor and the memory/bus wrapper.
- Sequences one transaction at a time with a req/ack handshake and gives data accesses priority over fetches.
- Drives a stall to the core until every access the core requested in the current cycle has completed; aborts hung transactions on a timeout.

Parameters:
DATA_WIDTH, 32, width of instruction, data and memory data buses
INST_ADDR_WIDTH, 20, instruction address width from the core
DATA_ADDR_WIDTH, 32, data address width from the core
MEM_ADDR_WIDTH, 32, external bus address width (>= both core address widths)
TIMEOUT_CYCLES, 255, cycles waited for mem_ack before abort (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; synchronous, active-high
instr_rd_en  in  1  core fetch request (level)
instr_addr  in  INST_ADDR_WIDTH  fetch address
instruction  out  DATA_WIDTH  fetched word, registered
data_rd_en  in  1  core load request (level)
data_wr_en  in  1  core store request (level)
data_addr  in  DATA_ADDR_WIDTH  load/store address
data_write  in  DATA_WIDTH  store data
data_read  out  DATA_WIDTH  load data, registered
core_stall  out  1  core must hold its pipeline
mem_req  out  1  bus request, registered
mem_we  out  1  1 = write
mem_addr  out  MEM_ADDR_WIDTH  bus address, zero-extended
mem_wdata  out  DATA_WIDTH  bus write data
mem_rdata  in  DATA_WIDTH  bus read data, valid with mem_ack
mem_ack  in  1  one-cycle transaction complete
bus_error  out  1  sticky timeout flag

Behaviour:
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instruction=0, data_read=0, bus_error=0, done_i=0, done_d=0, state IDLE, timeout counter 0.
- Reset mid-transaction: mem_req is low in the cycle after rst is sampled. Any late mem_ack is ignored because acks are ignored outside ACCESS.
- data_req = data_rd_en | data_wr_en. If both enables are high, the access is treated as a write.
- pend_d = data_req & !done_d; pend_i = instr_rd_en & !done_i.
- core_stall = pend_d | pend_i (combinational).
- FSM states: IDLE, ACCESS, RESP.
- IDLE, pend_d: latch port=DATA, mem_we=data_wr_en, mem_addr=data_addr, mem_wdata=data_write; assert mem_req; go to ACCESS.
- IDLE, pend_i and no pend_d: latch port=INST, mem_we=0, mem_addr=instr_addr; assert mem_req; go to ACCESS. Data always has priority.
- IDLE, no pending request: stay in IDLE.
- IDLE, both done flags set and core_stall=0: clear done_i and done_d.
- ACCESS: mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack; the counter increments each cycle.
- ACCESS, mem_ack: drop mem_req. Capture mem_rdata into instruction (INST) or data_read (DATA read; writes leave data_read unchanged). Set done_i or done_d. Go to RESP.
- ACCESS, no mem_ack and counter reaches TIMEOUT_CYCLES: drop mem_req, set bus_error, load 0 into the destination register (reads only), set the done flag, go to RESP.
- RESP: lasts one cycle, then IDLE; the counter clears.
- Done flags clear in the cycle core_stall is 0 (the core advances), so the next cycle's requests are treated as new.
- Latency: request seen at T in IDLE; mem_req high from T+1; mem_ack at T+k (k>=1); result registered and core_stall low at T+k+1 if nothing else is pending.
- Back-to-back: a new access needs at least 3 cycles from the previous request.
- Simultaneous load and fetch: data completes first, then the fetch; core_stall stays high until both complete.
- bus_error stays set until rst; the arbiter keeps operating after an error.
- mem_ack while in IDLE or RESP is ignored.

Test Plan:
- Fetch only: instr_rd_en=1, instr_addr=20'h40000; mem_ack 2 cycles after mem_req with rdata=32'h20010005. Expect mem_addr=32'h00040000, mem_we=0, core_stall high 3 cycles then low, instruction=32'h20010005.
- Store plus fetch in the same cycle: data_wr_en=1, data_addr=32'h100, data_write=32'hCAFEF00D; instr_rd_en=1. Expect first transaction we=1, addr 32'h100, wdata CAFEF00D, then a fetch; core_stall drops only after the second ack; data_read unchanged.
- Load: data_rd_en=1, addr 32'h200, ack with rdata=32'h12345678 in the same cycle mem_req rises. Expect data_read=32'h12345678 and the stall released at T+2.
- Timeout with TIMEOUT_CYCLES=4: fetch, never ack. Expect mem_req high exactly 4 cycles, bus_error=1, instruction=0, stall released; the next fetch with ack succeeds and bus_error stays 1.
- Reset mid-ACCESS: assert rst while mem_req=1, then send a stray mem_ack. Expect all outputs at reset values next cycle, the stray ack ignored, and bus_error=0.
- Both data_rd_en and data_wr_en high: expect a single write transaction (mem_we=1) with data_read unchanged.

Source files
------------

// File: rtl/dlx_mem_arbiter.sv
// Shares one single-ported memory bus between the uDLX fetch and data ports.
// One transaction at a time, data before fetch, core stalled until all requested accesses finish.
module dlx_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 20,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_rd_en,
  input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0]      instruction,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       core_stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_ack,
  output logic                       bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic {PORT_INST, PORT_DATA} port_t;

  // Abort fires in the ACCESS cycle whose count would reach TIMEOUT_CYCLES.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                    state_q, state_d;
  port_t                     port_q, port_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      done_i_q, done_i_d;
  logic                      done_d_q, done_d_d;
  logic                      bus_error_q, bus_error_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]     instruction_q, instruction_d;
  logic [DATA_WIDTH-1:0]     data_read_q, data_read_d;

  logic data_req, pend_d, pend_i;

  assign data_req   = data_rd_en | data_wr_en;
  assign pend_d     = data_req & ~done_d_q;
  assign pend_i     = instr_rd_en & ~done_i_q;
  assign core_stall = pend_d | pend_i;

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign instruction = instruction_q;
  assign data_read   = data_read_q;
  assign bus_error   = bus_error_q;

  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    cnt_d         = cnt_q;
    done_i_d      = done_i_q;
    done_d_d      = done_d_q;
    bus_error_d   = bus_error_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    instruction_d = instruction_q;
    data_read_d   = data_read_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pend_d) begin
          port_d      = PORT_DATA;
          mem_we_d    = data_wr_en;
          mem_addr_d  = MEM_ADDR_WIDTH'(data_addr);
          mem_wdata_d = data_write;
          mem_req_d   = 1'b1;
          state_d     = S_ACCESS;
        end else if (pend_i) begin
          port_d     = PORT_INST;
          mem_we_d   = 1'b0;
          mem_addr_d = MEM_ADDR_WIDTH'(instr_addr);
          mem_req_d  = 1'b1;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack || cnt_q == TO_LAST) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
          if (!mem_ack) bus_error_d = 1'b1;
          // A timed-out read returns zero; writes never touch data_read.
          if (port_q == PORT_DATA) begin
            done_d_d = 1'b1;
            if (!mem_we_q) data_read_d = mem_ack ? mem_rdata : '0;
          end else begin
            done_i_d      = 1'b1;
            instruction_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Core advances this cycle, so its next requests count as new ones.
    if (!core_stall) begin
      done_i_d = 1'b0;
      done_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      port_q        <= PORT_INST;
      cnt_q         <= '0;
      done_i_q      <= 1'b0;
      done_d_q      <= 1'b0;
      bus_error_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instruction_q <= '0;
      data_read_q   <= '0;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      cnt_q         <= cnt_d;
      done_i_q      <= done_i_d;
      done_d_q      <= done_d_d;
      bus_error_q   <= bus_error_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      instruction_q <= instruction_d;
      data_read_q   <= data_read_d;
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Bench for dlx_mem_arbiter: per-operation timeline model built from the latency rules,
// checked every cycle at the falling edge, plus literal spot checks.
module tb_dlx_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_rd_en = 1'b0;
  logic [19:0] instr_addr = '0;
  logic [31:0] instruction;
  logic        data_rd_en = 1'b0;
  logic        data_wr_en = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_write = '0;
  logic [31:0] data_read;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        bus_error;

  dlx_mem_arbiter #(
    .DATA_WIDTH(32), .INST_ADDR_WIDTH(20), .DATA_ADDR_WIDTH(32),
    .MEM_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_rd_en(instr_rd_en), .instr_addr(instr_addr), .instruction(instruction),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
    .data_write(data_write), .data_read(data_read), .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  logic exp_req = 1'b0, exp_stall = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_instr = '0, exp_dread = '0;
  int obs_stall = 0, obs_req = 0;
  string op_name = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s [%s] t=%0t got=%h want=%h", name, op_name, $time, act, req);
    end
  endtask

  // Per-cycle compare against the timeline model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("core_stall", 32'(core_stall), 32'(exp_stall));
      check("bus_error", 32'(bus_error), 32'(exp_err));
      check("instruction", instruction, exp_instr);
      check("data_read", data_read, exp_dread);
      if (exp_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (core_stall) obs_stall++;
      if (mem_req) obs_req++;
    end
  end

  // One core operation: optional data access and/or fetch raised together.
  // k = ack delay counted in mem_req cycles (1 = same cycle mem_req rises); 0 = never ack.
  task automatic run_op(input string name,
                        input bit drd, input bit dwr, input logic [31:0] daddr,
                        input logic [31:0] wdat, input int kd, input logic [31:0] rdd,
                        input bit ireq, input logic [19:0] iaddr, input int ki,
                        input logic [31:0] rdi, input bit stray);
    int n, last_e;
    bit is_data [2];
    int s [2];
    int len [2];
    int k [2];
    logic [31:0] rdat [2];
    n = 0;
    op_name = name;
    if (drd | dwr) begin is_data[n] = 1'b1; k[n] = kd; rdat[n] = rdd; n++; end
    if (ireq)      begin is_data[n] = 1'b0; k[n] = ki; rdat[n] = rdi; n++; end
    s[0] = 0;
    for (int j = 0; j < n; j++) begin
      len[j] = (k[j] > 0) ? k[j] : TO;
      if (j + 1 < n) s[j+1] = s[j] + len[j] + 2;
    end
    last_e = s[n-1] + len[n-1];
    obs_stall = 0;
    obs_req = 0;
    for (int c = 0; c <= last_e + 2; c++) begin
      @(posedge clk); #1;
      if (c <= last_e + 1) begin
        data_rd_en = drd; data_wr_en = dwr; data_addr = daddr; data_write = wdat;
        instr_rd_en = ireq; instr_addr = iaddr;
      end else begin
        data_rd_en = 1'b0; data_wr_en = 1'b0; instr_rd_en = 1'b0;
      end
      mem_ack = 1'b0;
      mem_rdata = 32'hDEADBEEF;
      if (stray && c == last_e + 1) begin mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; end
      exp_req = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (k[j] > 0 && c == s[j] + k[j]) begin mem_ack = 1'b1; mem_rdata = rdat[j]; end
        if (c >= s[j] + 1 && c <= s[j] + len[j]) begin
          exp_req = 1'b1;
          exp_we = is_data[j] & dwr;
          exp_addr = is_data[j] ? daddr : {12'h000, iaddr};
          exp_wdata = wdat;
        end
        if (c == s[j] + len[j] + 1) begin
          if (k[j] == 0) exp_err = 1'b1;
          if (is_data[j]) begin
            if (!dwr) exp_dread = (k[j] > 0) ? rdat[j] : 32'h0;
          end else begin
            exp_instr = (k[j] > 0) ? rdat[j] : 32'h0;
          end
        end
      end
      exp_stall = (c <= last_e);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_stall", 32'(core_stall), 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    chk_en = 1'b1;

    run_op("fetch", 0, 0, 0, 0, 0, 0, 1, 20'h40000, 2, 32'h20010005, 0);
    check("fetch_stall_cycles", 32'(obs_stall), 32'd3);
    check("fetch_instr_lit", instruction, 32'h20010005);

    run_op("store_fetch", 0, 1, 32'h100, 32'hCAFEF00D, 1, 32'h11111111,
           1, 20'h00123, 3, 32'h0BADF00D, 1);
    check("store_fetch_req_cycles", 32'(obs_req), 32'd4);
    check("store_fetch_dread_lit", data_read, 32'h0);

    run_op("load", 1, 0, 32'h200, 0, 1, 32'h12345678, 0, 0, 0, 0, 0);
    check("load_stall_cycles", 32'(obs_stall), 32'd2);
    check("load_dread_lit", data_read, 32'h12345678);

    run_op("fetch_timeout", 0, 0, 0, 0, 0, 0, 1, 20'h00500, 0, 0, 0);
    check("timeout_req_cycles", 32'(obs_req), 32'd4);
    check("timeout_err_lit", 32'(bus_error), 32'h1);
    check("timeout_instr_lit", instruction, 32'h0);

    run_op("fetch_after_err", 0, 0, 0, 0, 0, 0, 1, 20'hFFFFF, 2, 32'hA5A5A5A5, 1);
    check("after_err_instr_lit", instruction, 32'hA5A5A5A5);

    run_op("load_and_fetch", 1, 0, 32'h80000004, 0, 2, 32'h55AA55AA,
           1, 20'h00008, 1, 32'h01020304, 1);
    check("load_fetch_stall_cycles", 32'(obs_stall), 32'd6);

    run_op("rd_and_wr", 1, 1, 32'h300, 32'h600DD00D, 1, 32'h77777777, 0, 0, 0, 0, 0);
    check("rd_wr_dread_lit", data_read, 32'h55AA55AA);

    run_op("load_timeout", 1, 0, 32'h404, 0, 0, 0, 0, 0, 0, 0, 0);
    check("load_timeout_dread_lit", data_read, 32'h0);

    // Reset in the middle of a fetch, then a stray ack.
    chk_en = 1'b0;
    op_name = "reset_mid";
    @(posedge clk); #1;
    instr_rd_en = 1'b1; instr_addr = 20'h00777;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_req_high", 32'(mem_req), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; instr_rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_err", 32'(bus_error), 32'h0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_instr", instruction, 32'h0);
    check("mid_rst_dread", data_read, 32'h0);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_instr", instruction, 32'h0);
    check("stray_ack_req", 32'(mem_req), 32'h0);
    check("stray_ack_stall", 32'(core_stall), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
